// File: rtl/pulse_gen_multi.sv
// Multi-channel burst pulse generator sharing one free-running Fibonacci LFSR for gap randomisation.
// Optional `PULSE_GEN_SEED_LOAD_EN adds seed_load/seed_data for runtime LFSR reseeding.
`timescale 1ns/1ps

module pulse_gen_multi #(
    parameter int                  NUM_BITS = 9,
    parameter logic [NUM_BITS-1:0] TAPS     = 9'h110,
    parameter logic [NUM_BITS-1:0] SEED     = 9'h001,
    parameter int                  GAP_BITS = 4,
    parameter int                  MIN_GAP  = 4,
    parameter int                  NUM_CH   = 4,
    parameter int                  CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   start,
    input  logic [NUM_CH-1:0]   stop,
    input  logic [CNT_W-1:0]    cfg_num_pulses,
    input  logic [CNT_W-1:0]    cfg_width,
    input  logic                cfg_continuous,
`ifdef PULSE_GEN_SEED_LOAD_EN
    input  logic                seed_load,
    input  logic [NUM_BITS-1:0] seed_data,
`endif
    output logic [NUM_CH-1:0]   pulse_out,
    output logic [NUM_CH-1:0]   done_out,
    output logic [NUM_CH-1:0]   busy_out
);

    localparam int GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS));

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        HIGH,
        DONE
    } state_e;

    logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
    logic [GAP_W-1:0]    gap_sample;

    always_comb begin
        lfsr_d = {lfsr_q[NUM_BITS-2:0], ^(lfsr_q & TAPS)};
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
`ifdef PULSE_GEN_SEED_LOAD_EN
        if (seed_load) begin
            lfsr_d = (seed_data == '0) ? SEED : seed_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gap_sample = GAP_W'(lfsr_q[GAP_BITS-1:0]) + GAP_W'(MIN_GAP);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e           state_q;
        logic [GAP_W-1:0] gap_q;
        logic [CNT_W-1:0] wid_q;
        logic [CNT_W-1:0] wcnt_q;
        logic [CNT_W-1:0] num_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W:0]   cnt_inc;
        logic             cont_q;
        logic             pulse_q;
        logic             done_q;
        logic             busy_q;

        assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

        // Outputs are registered views of the state held during the previous cycle,
        // so busy stays high through the done strobe; stop clears them on its edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                gap_q   <= '0;
                wid_q   <= '0;
                wcnt_q  <= '0;
                num_q   <= '0;
                cnt_q   <= '0;
                cont_q  <= 1'b0;
                pulse_q <= 1'b0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (start[g] && !stop[g]) begin
                            num_q  <= cfg_num_pulses;
                            wid_q  <= (cfg_width == '0) ? CNT_W'(1) : cfg_width;
                            cont_q <= cfg_continuous;
                            cnt_q  <= '0;
                            gap_q  <= gap_sample;
                            busy_q <= 1'b1;
                            state_q <= (cfg_num_pulses == '0 && !cfg_continuous) ? DONE : GAP;
                        end
                    end
                    GAP: begin
                        if (stop[g]) begin
                            state_q <= IDLE;
                        end else begin
                            busy_q <= 1'b1;
                            if (gap_q == GAP_W'(1)) begin
                                wcnt_q  <= wid_q;
                                state_q <= HIGH;
                            end else begin
                                gap_q <= gap_q - GAP_W'(1);
                            end
                        end
                    end
                    HIGH: begin
                        if (stop[g]) begin
                            state_q <= IDLE;
                        end else begin
                            busy_q  <= 1'b1;
                            pulse_q <= 1'b1;
                            if (wcnt_q == CNT_W'(1)) begin
                                if (!cont_q || cnt_q != '1) begin
                                    cnt_q <= cnt_inc[CNT_W-1:0];
                                end
                                if (!cont_q && cnt_inc == {1'b0, num_q}) begin
                                    state_q <= DONE;
                                end else begin
                                    gap_q   <= gap_sample;
                                    state_q <= GAP;
                                end
                            end else begin
                                wcnt_q <= wcnt_q - CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        if (!stop[g]) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign pulse_out[g] = pulse_q;
        assign done_out[g]  = done_q;
        assign busy_out[g]  = busy_q;
    end

endmodule
